// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operation sequencer.
// Opcodes, FSM state encoding, flag bit positions, opcode legality.
package fpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_SQRT = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int FLG_EXC = 0;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 2;
    localparam int FLG_ILL = 3;
    localparam int FLG_TMO = 4;

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL,
            OP_DIV, OP_SQRT: ok = 1'b1;
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fpu_tmo_counter.sv
// Timeout guard for the WAIT state.
// tc fires on the enabled cycle whose increment would reach TMO_CYCLES.
module fpu_tmo_counter #(
    parameter int TMO_CYCLES = 255,
    parameter int TMO_W      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYCLES - 1);

    logic [TMO_W-1:0] cnt;

    // Count WAIT cycles; cleared when an op is launched
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issue/complete controller between register-file front end and FP units.
// One op in flight; launches with a start pulse and returns result + flags.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int TMO_CYCLES = 255,
    parameter int TMO_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             unit_start,
    output logic [2:0]       unit_op,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    input  logic             unit_done,
    input  logic [WIDTH-1:0] unit_result,
    input  logic [2:0]       unit_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_flags,
    output logic [4:0]       sticky_flags,
    input  logic             clr_sticky
);

    localparam logic [4:0] FLAGS_ILL = 5'(1 << FLG_ILL);
    localparam logic [4:0] FLAGS_TMO = 5'(1 << FLG_TMO);

    state_t state_q;
    state_t state_d;
    logic   cnt_clr;
    logic   cnt_en;
    logic   tmo_hit;
    logic   resp_hs;

    fpu_tmo_counter #(
        .TMO_CYCLES (TMO_CYCLES),
        .TMO_W      (TMO_W)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (tmo_hit)
    );

    assign resp_hs = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/launch strobes
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        unit_start = 1'b0;
        out_valid  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = op_legal(in_op) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                unit_start = 1'b1;
                cnt_clr    = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (unit_done) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                    if (tmo_hit) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture and response latching; done beats a same-cycle timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            unit_op    <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                unit_op <= in_op;
                unit_a  <= in_a;
                unit_b  <= in_b;
                if (!op_legal(in_op)) begin
                    out_result <= '0;
                    out_flags  <= FLAGS_ILL;
                end
            end
            if (state_q == ST_WAIT) begin
                if (unit_done) begin
                    out_result <= unit_result;
                    out_flags  <= {2'b00, unit_flags};
                end else if (tmo_hit) begin
                    out_result <= '0;
                    out_flags  <= FLAGS_TMO;
                end
            end
        end
    end

    // Sticky status: new flags from a handshake survive a coincident clear
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_flags <= '0;
        end else begin
            sticky_flags <= (clr_sticky ? 5'b0 : sticky_flags)
                          | (resp_hs ? out_flags : 5'b0);
        end
    end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Parametrised issue/complete controller that sits between the register-file front end and the floating-point arithmetic units (add/sub, mul, div, sqrt).
- Accepts one operation at a time over a valid/ready handshake and launches it on the arithmetic-unit interface with a one-cycle start pulse.
- Waits for the unit's done, with a timeout guard, then returns the result and status over a valid/ready handshake.
- Accumulates sticky IEEE-style status flags and rejects illegal opcodes without launching anything.

Parameters:
- WIDTH, 64, operand/result width (32 or 64).
- TMO_CYCLES, 255, maximum cycles spent in WAIT before a timeout abort (1..65535).
- TMO_W, 16, width of the timeout counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept a request
- in_op  in  3  opcode: 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 SQRT; 0, 6, 7 illegal
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored for SQRT)
- unit_start  out  1  one-cycle launch pulse
- unit_op  out  3  registered opcode
- unit_a  out  WIDTH  registered operand A
- unit_b  out  WIDTH  registered operand B
- unit_done  in  1  selected unit finished (level or pulse)
- unit_result  in  WIDTH  unit result, valid with unit_done
- unit_flags  in  3  {underflow, overflow, exception}, valid with unit_done
- out_valid  out  1  response valid
- out_ready  in  1  consumer accepts response
- out_result  out  WIDTH  result
- out_flags  out  5  {timeout, illegal, underflow, overflow, exception} for this op
- sticky_flags  out  5  OR-accumulated out_flags
- clr_sticky  in  1  clear sticky_flags

Behaviour:
- Clock is clk; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset: state IDLE; in_ready=1; unit_start=0; out_valid=0; out_result=0; out_flags=0; sticky_flags=0; unit_op/a/b=0; timeout counter=0.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid, capture op/a/b into the unit_* registers.
  - Legal op: go to ISSUE.
  - Illegal op: go to RESP with out_result=0, out_flags=5'b01000.
- ISSUE: unit_start=1 for exactly this cycle; counter cleared; next state WAIT. in_ready=0.
- WAIT:
  - unit_done=1: latch unit_result and {2'b00, unit_flags}, then go to RESP.
  - Otherwise the counter increments. When the counter reaches TMO_CYCLES without done, go to RESP with out_result=0, out_flags=5'b10000.
  - unit_done arriving on the same cycle the counter hits TMO_CYCLES counts as completion, not timeout.
- RESP:
  - out_valid=1. out_result and out_flags are held stable until the handshake.
  - On out_ready: out_valid=0 next cycle, state IDLE.
  - sticky_flags |= out_flags on the handshake cycle only.
- Latency: request handshake at cycle T gives unit_start at T+1. A done at cycle D gives out_valid at D+1. An illegal op gives out_valid at T+1.
- Throughput: one op outstanding. The next request can be accepted the cycle after the response handshake.
- clr_sticky: clears sticky_flags next cycle. If it coincides with a response handshake, the new out_flags are kept (set wins over clear).
- unit_done seen outside WAIT is ignored.
- Reset mid-operation: abort immediately, return to reset values. No response is produced for the aborted op and unit_start is never re-pulsed.
- Widths: for WIDTH=32, only the low 32 bits are meaningful. The sequencer never inspects data bits, it only routes them.

Decomposition:
- Shared package fpu_pkg holds:
  - opcode localparams: OP_ADD=3'd1, OP_SUB=3'd2, OP_MUL=3'd3, OP_DIV=3'd4, OP_SQRT=3'd5;
  - state encoding;
  - flag bit indices: FLG_EXC=0, FLG_OVF=1, FLG_UNF=2, FLG_ILL=3, FLG_TMO=4;
  - an op-legality function.
- One natural sub-module: fpu_tmo_counter (clear, enable, terminal-count compare at TMO_CYCLES). The FSM and data registers stay in the top module.

Test Plan:
1. ADD, a=64'h3FF0000000000000, b=64'h4000000000000000, unit_done 3 cycles after start with result 64'h4008000000000000 -> unit_start pulse width 1, out_valid one cycle after done, out_result=64'h4008000000000000, out_flags=0.
2. in_op=3'd7 -> no unit_start; out_valid at T+1; out_result=0; out_flags=5'b01000; sticky_flags=5'b01000 after the handshake.
3. TMO_CYCLES=8, DIV with unit_done never asserted -> out_flags=5'b10000, out_result=0, out_valid 9 cycles after unit_start. Repeat with unit_done on the terminal cycle -> completion wins, no timeout flag.
4. MUL returning unit_flags=3'b010, out_ready held low for 5 cycles -> out_valid/out_result/out_flags stay stable, in_ready=0 throughout. sticky_flags becomes 5'b00010 only on the handshake cycle. Next request is accepted the following cycle.
5. clr_sticky asserted on the same cycle as a handshake carrying 5'b00001, with prior sticky 5'b01000 -> sticky_flags=5'b00001.
6. reset asserted during WAIT -> next cycle state IDLE, in_ready=1, out_valid=0, sticky_flags=0. A late unit_done produces no response.
